// File: rtl/instr_line_buffer_pkg.sv
// Shared front-end fetch types: line geometry and the line-buffer FSM encoding.
package rv32i_types;

  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned WORDS     = LINE_BITS / WORD_BITS;
  localparam int unsigned OFFSET_W  = $clog2(LINE_BITS / 8);
  localparam int unsigned TAG_W     = ADDR_W - OFFSET_W;
  localparam int unsigned WIDX_W    = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    FETCH
  } fetch_state_t;

  typedef logic [LINE_BITS-1:0] line_t;

endpackage

// File: rtl/instr_line_buffer.sv
// Single-line instruction buffer: serves 32-bit words from one cached 256-bit line and
// refills it over the pmem read handshake on a miss; flush cancels an in-flight refill.
module instr_line_buffer
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_read,
  input  logic [ADDR_W-1:0]    instr_mem_address,
  input  logic                 flush,
  output logic                 instr_mem_resp,
  output logic [WORD_BITS-1:0] instr_rdata,
  output logic                 pmem_read,
  output logic [ADDR_W-1:0]    pmem_address,
  input  logic                 pmem_resp,
  input  line_t                pmem_rdata
);

  fetch_state_t state_q, state_d;
  line_t        line_q, line_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic         valid_q, valid_d;
  logic         drop_q, drop_d;

  logic                 resp_d;
  logic [WORD_BITS-1:0] rdata_d;
  logic                 pmem_read_d;
  logic [ADDR_W-1:0]    pmem_address_d;

  logic [TAG_W-1:0]  req_tag_c;
  logic [WIDX_W-1:0] req_word_c;
  logic              hit_c;
  logic              unused_addr_bits_c;

  // Byte-within-word bits are don't-care: fetches are word aligned.
  assign req_tag_c          = instr_mem_address[ADDR_W-1:OFFSET_W];
  assign req_word_c         = instr_mem_address[OFFSET_W-1:2];
  assign hit_c              = valid_q && (tag_q == req_tag_c);
  assign unused_addr_bits_c = ^instr_mem_address[1:0];

  // Next-state and next-register values.
  always_comb begin
    state_d        = state_q;
    line_d         = line_q;
    tag_d          = tag_q;
    valid_d        = valid_q;
    drop_d         = drop_q;
    resp_d         = 1'b0;
    rdata_d        = instr_rdata;
    pmem_read_d    = pmem_read;
    pmem_address_d = pmem_address;

    case (state_q)
      IDLE: begin
        if (instr_read && !flush) begin
          if (hit_c) begin
            resp_d  = 1'b1;
            rdata_d = line_q[req_word_c*WORD_BITS +: WORD_BITS];
            state_d = RESP;
          end else begin
            pmem_read_d    = 1'b1;
            pmem_address_d = {req_tag_c, OFFSET_W'(0)};
            drop_d         = 1'b0;
            state_d        = FETCH;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      FETCH: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        // A redirect seen at any point during the refill invalidates the buffer.
        if (pmem_resp) begin
          if (!drop_q && !flush) begin
            line_d  = pmem_rdata;
            tag_d   = pmem_address[ADDR_W-1:OFFSET_W];
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
          drop_d      = 1'b0;
          pmem_read_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      line_q         <= '0;
      tag_q          <= '0;
      valid_q        <= 1'b0;
      drop_q         <= 1'b0;
      instr_mem_resp <= 1'b0;
      instr_rdata    <= '0;
      pmem_read      <= 1'b0;
      pmem_address   <= '0;
    end else begin
      state_q        <= state_d;
      line_q         <= line_d;
      tag_q          <= tag_d;
      valid_q        <= valid_d;
      drop_q         <= drop_d;
      instr_mem_resp <= resp_d;
      instr_rdata    <= rdata_d;
      pmem_read      <= pmem_read_d;
      pmem_address   <= pmem_address_d;
    end
  end

endmodule

// File: tb/tb_instr_line_buffer.sv
// Bench for instr_line_buffer: transaction-level buffer model checked every cycle, plus
// directed scenarios with literal expectations for latency, data and flush/reset behaviour.
module tb_instr_line_buffer;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        flush;
  logic        instr_mem_resp;
  logic [31:0] instr_rdata;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic        pmem_resp;
  line_t       pmem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_line_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .flush             (flush),
    .instr_mem_resp    (instr_mem_resp),
    .instr_rdata       (instr_rdata),
    .pmem_read         (pmem_read),
    .pmem_address      (pmem_address),
    .pmem_resp         (pmem_resp),
    .pmem_rdata        (pmem_rdata)
  );

  // Backing memory contents: each word is its own address xor a marker, except two
  // words in line 0x60 that hold a known instruction.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a ^ 32'hC0DE_0000;
    if ((a & ~32'h1f) == 32'h60 && (a[4:2] == 3'd0 || a[4:2] == 3'd3)) w = 32'h0001_70b3;
    return w;
  endfunction

  function automatic line_t mem_line(input logic [31:0] base);
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word(base + 32'(4 * i));
    return l;
  endfunction

  // Buffer model: remembers which line (if any) it holds and what it is doing.
  typedef enum {M_IDLE, M_ANSWER, M_REFILL} mphase_t;
  mphase_t     m_phase;
  logic [31:0] m_words [8];
  logic [31:0] m_base;
  logic        m_valid;
  logic        m_redirected;
  logic        e_resp;
  logic [31:0] e_rdata;
  logic        e_pread;
  logic [31:0] e_paddr;

  always @(posedge clk) begin
    if (rst) begin
      m_phase      <= M_IDLE;
      m_valid      <= 1'b0;
      m_redirected <= 1'b0;
      m_base       <= '0;
      e_resp       <= 1'b0;
      e_rdata      <= '0;
      e_pread      <= 1'b0;
      e_paddr      <= '0;
    end else begin
      e_resp <= 1'b0;
      case (m_phase)
        M_IDLE: begin
          if (instr_read && !flush) begin
            if (m_valid && (instr_mem_address & ~32'h1f) == m_base) begin
              e_resp  <= 1'b1;
              e_rdata <= m_words[instr_mem_address[4:2]];
              m_phase <= M_ANSWER;
            end else begin
              e_pread      <= 1'b1;
              e_paddr      <= instr_mem_address & ~32'h1f;
              m_redirected <= 1'b0;
              m_phase      <= M_REFILL;
            end
          end
        end
        M_ANSWER: m_phase <= M_IDLE;
        default: begin
          if (flush) m_redirected <= 1'b1;
          if (pmem_resp) begin
            if (!m_redirected && !flush) begin
              m_valid <= 1'b1;
              m_base  <= e_paddr;
              for (int i = 0; i < 8; i++) m_words[i] <= pmem_rdata[32*i +: 32];
            end else begin
              m_valid <= 1'b0;
            end
            m_redirected <= 1'b0;
            e_pread      <= 1'b0;
            m_phase      <= M_IDLE;
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every bench cycle ends here: step to the falling edge and compare against the model.
  task automatic tick();
    @(negedge clk);
    check("model.instr_mem_resp", 32'(instr_mem_resp), 32'(e_resp));
    check("model.instr_rdata", instr_rdata, e_rdata);
    check("model.pmem_read", 32'(pmem_read), 32'(e_pread));
    check("model.pmem_address", pmem_address, e_paddr);
  endtask

  // Issue one fetch, act as memory with the given latency, and report what happened.
  task automatic do_fetch(input logic [31:0] addr, input int lat, output logic [31:0] data,
                          output int cyc, output logic missed, output logic [31:0] paddr);
    int fcnt;
    bit done;
    fcnt = 0; done = 0; cyc = 0; missed = 0; data = '0; paddr = '0;
    instr_read = 1'b1;
    instr_mem_address = addr;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      if (instr_mem_resp) begin
        done = 1;
        data = instr_rdata;
        instr_read = 1'b0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if (pmem_read) begin
        if (!missed) paddr = pmem_address;
        missed = 1;
        fcnt++;
        if (fcnt >= lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_line(addr & ~32'h1f);
        end
      end
    end
    if (!done) check("fetch.timeout", 32'(done), 32'd1);
    instr_read = 1'b0;
    pmem_resp  = 1'b0;
  endtask

  task automatic wait_pread();
    int n;
    n = 0;
    while (!pmem_read && n < 20) begin
      tick();
      n++;
    end
    check("wait.pmem_read", 32'(pmem_read), 32'd1);
  endtask

  logic [31:0] data, paddr;
  int          cyc;
  logic        missed;
  logic        resp_hist [8];

  initial begin
    rst = 1'b1; instr_read = 1'b0; instr_mem_address = '0; flush = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick(); tick();
    check("reset.resp", 32'(instr_mem_resp), 32'd0);
    check("reset.rdata", instr_rdata, 32'd0);
    check("reset.pmem_read", 32'(pmem_read), 32'd0);
    check("reset.pmem_address", pmem_address, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss on line 0x60, memory answers after one cycle.
    do_fetch(32'h60, 1, data, cyc, missed, paddr);
    check("t1.missed", 32'(missed), 32'd1);
    check("t1.pmem_address", paddr, 32'h60);
    check("t1.rdata", data, 32'h0001_70b3);
    check("t1.latency", 32'(cyc), 32'd3);
    tick();
    check("t1.pmem_read_low", 32'(pmem_read), 32'd0);

    // Rest of the line hits with one-cycle latency.
    for (int a = 32'h64; a <= 32'h7C; a += 4) begin
      do_fetch(32'(a), 1, data, cyc, missed, paddr);
      check("t2.hit", 32'(missed), 32'd0);
      check("t2.latency", 32'(cyc), 32'd1);
      check("t2.rdata", data, mem_word(32'(a)));
      tick();
    end
    check("t2.last_word", data, 32'hC0DE_007C);

    // New line evicts the old one; memory latency 2.
    do_fetch(32'h84, 2, data, cyc, missed, paddr);
    check("t3.missed", 32'(missed), 32'd1);
    check("t3.pmem_address", paddr, 32'h80);
    check("t3.latency", 32'(cyc), 32'd4);
    check("t3.rdata", data, 32'hC0DE_0084);
    tick();
    do_fetch(32'h6C, 1, data, cyc, missed, paddr);
    check("t3.old_line_miss", 32'(missed), 32'd1);
    check("t3.old_line_rdata", data, 32'h0001_70b3);
    tick();

    // Flush while refilling 0x100: response discarded, buffer invalidated.
    instr_read = 1'b1; instr_mem_address = 32'h100;
    wait_pread();
    flush = 1'b1; instr_read = 1'b0;
    tick();
    flush = 1'b0;
    tick(); tick();
    pmem_resp = 1'b1; pmem_rdata = mem_line(32'h100);
    tick();
    pmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4.no_resp", 32'(instr_mem_resp), 32'd0);
    end
    do_fetch(32'h60, 1, data, cyc, missed, paddr);
    check("t4.invalidated", 32'(missed), 32'd1);
    tick();
    do_fetch(32'h100, 1, data, cyc, missed, paddr);
    check("t4.refetch", 32'(missed), 32'd1);
    check("t4.refetch_addr", paddr, 32'h100);
    check("t4.rdata", data, 32'hC0DE_0100);
    tick();

    // Flush in the same cycle as the memory response.
    instr_read = 1'b1; instr_mem_address = 32'h200;
    wait_pread();
    pmem_resp = 1'b1; pmem_rdata = mem_line(32'h200); flush = 1'b1; instr_read = 1'b0;
    tick();
    pmem_resp = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5a.no_resp", 32'(instr_mem_resp), 32'd0);
    end
    do_fetch(32'h104, 1, data, cyc, missed, paddr);
    check("t5a.invalidated", 32'(missed), 32'd1);
    tick();

    // Reset in the middle of a refill; a stray response afterwards is ignored.
    instr_read = 1'b1; instr_mem_address = 32'h300;
    wait_pread();
    rst = 1'b1; instr_read = 1'b0;
    tick();
    check("t5b.pmem_read", 32'(pmem_read), 32'd0);
    check("t5b.resp", 32'(instr_mem_resp), 32'd0);
    check("t5b.rdata", instr_rdata, 32'd0);
    check("t5b.pmem_address", pmem_address, 32'd0);
    rst = 1'b0;
    tick();
    pmem_resp = 1'b1; pmem_rdata = mem_line(32'h300);
    tick();
    pmem_resp = 1'b0;
    tick();
    check("t5b.stray.pmem_read", 32'(pmem_read), 32'd0);
    check("t5b.stray.resp", 32'(instr_mem_resp), 32'd0);
    do_fetch(32'h100, 1, data, cyc, missed, paddr);
    check("t5b.valid_cleared", 32'(missed), 32'd1);
    tick();

    // Continuous request on a hit: at most one response every other cycle.
    instr_read = 1'b1; instr_mem_address = 32'h108;
    for (int k = 0; k < 8; k++) begin
      tick();
      resp_hist[k] = instr_mem_resp;
    end
    instr_read = 1'b0;
    for (int k = 0; k < 8; k++) check("t6.pattern", 32'(resp_hist[k]), 32'(k % 2 == 0));
    check("t6.rdata", instr_rdata, 32'hC0DE_0108);
    tick(); tick();

    // Flush in IDLE blocks acceptance for that cycle only.
    instr_read = 1'b1; instr_mem_address = 32'h10C; flush = 1'b1;
    tick();
    check("t7.flush_blocks", 32'(instr_mem_resp), 32'd0);
    check("t7.no_fetch", 32'(pmem_read), 32'd0);
    flush = 1'b0;
    tick();
    check("t7.after_flush", 32'(instr_mem_resp), 32'd1);
    check("t7.rdata", instr_rdata, 32'hC0DE_010C);
    instr_read = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
